eight_bit_alu: RTL and testbench

Registered 8-bit arithmetic/logic unit for the eight-bit CPU datapath. The decode stage drives it with the accumulator (operand_A), the zero-extended 5-bit immediate (operand_B) and a 3-bit opcode (alu_control); the result feeds back into the accumulator. The block computes ADD, SUB, AND, OR, XOR and pass-through operations, produces status flags, and registers all outputs with one cycle of latency.

---
 rtl/eight_bit_alu_if.sv | 27 ++
 rtl/eight_bit_alu.sv | 117 +++++++++++
 tb/tb_eight_bit_alu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/eight_bit_alu_if.sv
// eight_bit_alu_if: bundles the ALU operand/opcode inputs and its registered
// result/flag outputs.
//   master : decode stage (drives in_valid, operand_A, operand_B, alu_control;
//            observes result, out_valid and flags)
//   slave  : the ALU itself (the reverse directions)
interface eight_bit_alu_if;
  logic       in_valid;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic [2:0] alu_control;
  logic [7:0] result;
  logic       out_valid;
  logic       zero;
  logic       carry;
  logic       negative;
  logic       overflow;

  modport master (
    output in_valid, operand_A, operand_B, alu_control,
    input  result, out_valid, zero, carry, negative, overflow
  );

  modport slave (
    input  in_valid, operand_A, operand_B, alu_control,
    output result, out_valid, zero, carry, negative, overflow
  );
endinterface

// File: rtl/eight_bit_alu.sv
// eight_bit_alu: registered 8-bit ALU for the CPU datapath.
// Computes PASS_B, ADD, SUB, AND, OR, XOR, PASS_A (and 111 -> zero) on the
// accumulator (operand_A) and the zero-extended immediate (operand_B).
// All outputs are registered with one cycle of latency.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high; result=0, zero=1, other flags/out_valid=0
//   bus   : eight_bit_alu_if.slave (inputs in_valid/operands/opcode,
//           outputs result/out_valid/zero/carry/negative/overflow)
module eight_bit_alu (
  input  logic                 clk,
  input  logic                 reset,
  eight_bit_alu_if.slave       bus
);

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_OR     = 3'b100,
    OP_XOR    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_HLT    = 3'b111
  } alu_op_e;

  alu_op_e    op;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] res_new;
  logic       carry_new;
  logic       ovf_new;

  logic [7:0] result_d,   result_q;
  logic       zero_d,     zero_q;
  logic       carry_d,    carry_q;
  logic       negative_d, negative_q;
  logic       overflow_d, overflow_q;
  logic       out_valid_d, out_valid_q;

  assign op = alu_op_e'(bus.alu_control);

  // 9-bit forms: sum[8] is the carry-out, diff[8] is the borrow (A < B).
  assign sum  = {1'b0, bus.operand_A} + {1'b0, bus.operand_B};
  assign diff = {1'b0, bus.operand_A} - {1'b0, bus.operand_B};

  always_comb begin
    res_new   = '0;
    carry_new = 1'b0;
    ovf_new   = 1'b0;
    unique case (op)
      OP_PASS_B: res_new = bus.operand_B;
      OP_ADD: begin
        res_new   = sum[7:0];
        carry_new = sum[8];
        ovf_new   = (bus.operand_A[7] == bus.operand_B[7]) &&
                    (sum[7] != bus.operand_A[7]);
      end
      OP_SUB: begin
        res_new   = diff[7:0];
        carry_new = diff[8];
        ovf_new   = (bus.operand_A[7] != bus.operand_B[7]) &&
                    (diff[7] != bus.operand_A[7]);
      end
      OP_AND:    res_new = bus.operand_A & bus.operand_B;
      OP_OR:     res_new = bus.operand_A | bus.operand_B;
      OP_XOR:    res_new = bus.operand_A ^ bus.operand_B;
      OP_PASS_A: res_new = bus.operand_A;
      OP_HLT:    res_new = '0;
      default:   res_new = '0;
    endcase
  end

  // Outputs load only on a valid cycle and otherwise hold; out_valid simply
  // tracks whether this edge loaded new values.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      result_d   = res_new;
      zero_d     = (res_new == 8'h00);
      carry_d    = carry_new;
      negative_d = res_new[7];
      overflow_d = ovf_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_eight_bit_alu.sv
// Testbench for eight_bit_alu: directed vector table, hand-written sequences
// for reset/hold/throughput, and randomized ops against a reference model.
module tb_eight_bit_alu;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  eight_bit_alu_if bus ();

  eight_bit_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] r, input logic c,
                         input logic z, input logic n, input logic v, input logic ov);
    chk({tag, ".result"},    32'(bus.result),    32'(r));
    chk({tag, ".carry"},     32'(bus.carry),     32'(c));
    chk({tag, ".zero"},      32'(bus.zero),      32'(z));
    chk({tag, ".negative"},  32'(bus.negative),  32'(n));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(v));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
  endtask

  // Reference model from arithmetic rules: unsigned carry, signed-range overflow.
  function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, output logic [7:0] r,
                                output logic c, output logic v);
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = b;
      3'd1: begin
        t = ua + ub;
        r = 8'(t % 256);
        c = (t > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd2: begin
        t = ua - ub;
        r = 8'((t + 256) % 256);
        c = (ua < ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a;
      default: r = 8'h00;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge clk);
    bus.in_valid    = v;
    bus.alu_control = op;
    bus.operand_A   = a;
    bus.operand_B   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  logic [7:0] m_r;
  logic       m_c, m_z, m_n, m_v, m_ov;
  logic [7:0] nr;
  logic       nc, nv;
  logic       iv;
  logic [2:0] rop;
  logic [7:0] ra, rb;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{3'd2, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'd2, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 8'hF0, 8'h1C, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 8'hF0, 8'h1C, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'd5, 8'hF0, 8'h1C, 8'hEC, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd0, 8'hF0, 8'h1C, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'hF0, 8'h1C, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd7, 8'hF0, 8'h1C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for two edges while a valid ADD is presented.
    reset = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = 3'd1;
    bus.operand_A   = 8'h05;
    bus.operand_B   = 8'h03;
    tick();
    chk_all("reset1", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("reset2", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_all("post_reset_add", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].z,
              vecs[i].n, vecs[i].v, 1'b1);
    end

    // Back-to-back throughput then hold.
    drive(1'b1, 3'd1, 8'h01, 8'h02);
    tick();
    chk_all("b2b_add", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'd2, 8'h09, 8'h04);
    tick();
    chk_all("b2b_sub", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'd5, 8'hAA, 8'hFF);
    tick();
    chk_all("b2b_xor", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd1, 8'hFF - 8'(i), 8'h80 + 8'(i));
      tick();
      chk_all($sformatf("hold%0d", i), 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-stream: 21 appears, then reset wipes it for good.
    drive(1'b1, 3'd1, 8'h20, 8'h01);
    tick();
    chk_all("mid_add", 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk_all("mid_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("mid_after%0d", i), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Randomized ops against the model; model state starts from reset values.
    m_r = 8'h00; m_c = 1'b0; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 300; i++) begin
      iv  = ($urandom_range(0, 3) != 0);
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      drive(iv, rop, ra, rb);
      tick();
      if (iv) begin
        model(rop, ra, rb, nr, nc, nv);
        m_r = nr;
        m_c = nc;
        m_v = nv;
        m_z = (nr == 8'h00);
        m_n = (nr >= 8'h80);
      end
      m_ov = iv;
      chk_all($sformatf("rnd%0d", i), m_r, m_c, m_z, m_n, m_v, m_ov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
